// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns level requests into separated set/reset pulses for a
// downstream SR flop and keeps a shadow copy of the flop's output.
// After reset an optional clearing r pulse puts the flop in a known state.
// Each command is a pulse of PULSE_CYCLES cycles. An idle gap of GAP_CYCLES
// cycles follows it. s and r are never high together.

module sr_cmd_gen #(
   parameter int PULSE_CYCLES = 1,
   parameter int GAP_CYCLES   = 1,
   parameter bit INIT_CLEAR   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       in_data,
   output logic       in_ready,
   output logic       s,
   output logic       r,
   output logic       shadow_q,
   output logic       busy,
   output logic [7:0] cmd_cnt
);

   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_IDLE  = 2'd1;
   localparam logic [1:0] S_PULSE = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   // The counter holds the number of cycles still to spend in the current state
   // after this one. INIT is loaded with one extra count because the reset cycle
   // itself drives r low. The clearing pulse therefore starts on the first edge.
   localparam logic [4:0] C_PULSE_LOAD = 5'(PULSE_CYCLES - 1);
   localparam logic [4:0] C_GAP_LOAD   = 5'(GAP_CYCLES - 1);
   localparam logic [4:0] C_INIT_LOAD  = 5'(PULSE_CYCLES);
   localparam logic       C_GAP_EN     = (GAP_CYCLES != 0);
   localparam logic [1:0] C_RST_STATE  = INIT_CLEAR ? S_INIT : S_IDLE;
   localparam logic       C_RST_BUSY   = INIT_CLEAR;

   logic [1:0] r_state;
   logic [4:0] r_cnt;
   logic       r_level;
   logic       r_shadow;
   logic [7:0] r_cmd_cnt;
   logic       r_s;
   logic       r_r;
   logic       r_in_ready;
   logic       r_busy;

   logic [1:0] w_nstate;
   logic [4:0] w_ncnt;
   logic       w_nlevel;
   logic       w_nshadow;
   logic [7:0] w_ncmd_cnt;
   logic       w_xfer;

   assign w_xfer = in_valid & r_in_ready;

   // Next-state, counter, shadow and command-count computation.
   always_comb begin
      w_nstate   = r_state;
      w_ncnt     = r_cnt;
      w_nlevel   = r_level;
      w_nshadow  = r_shadow;
      w_ncmd_cnt = r_cmd_cnt;
      case (r_state)
         S_INIT: begin
            if (r_cnt == 5'd0) begin
               if (C_GAP_EN) begin
                  w_nstate = S_GAP;
                  w_ncnt   = C_GAP_LOAD;
               end else begin
                  w_nstate = S_IDLE;
                  w_ncnt   = 5'd0;
               end
            end else begin
               w_ncnt = r_cnt - 5'd1;
            end
         end
         S_IDLE: begin
            // A request equal to the tracked level needs no pulse at all.
            if (w_xfer && (in_data != r_shadow)) begin
               w_nstate   = S_PULSE;
               w_ncnt     = C_PULSE_LOAD;
               w_nlevel   = in_data;
               w_ncmd_cnt = r_cmd_cnt + 8'd1;
            end else begin
               w_nstate = S_IDLE;
            end
         end
         S_PULSE: begin
            if (r_cnt == 5'd0) begin
               w_nshadow = r_level;
               if (C_GAP_EN) begin
                  w_nstate = S_GAP;
                  w_ncnt   = C_GAP_LOAD;
               end else begin
                  w_nstate = S_IDLE;
                  w_ncnt   = 5'd0;
               end
            end else begin
               w_ncnt = r_cnt - 5'd1;
            end
         end
         S_GAP: begin
            if (r_cnt == 5'd0) begin
               w_nstate = S_IDLE;
               w_ncnt   = 5'd0;
            end else begin
               w_ncnt = r_cnt - 5'd1;
            end
         end
         default: begin
            w_nstate = C_RST_STATE;
            w_ncnt   = C_INIT_LOAD;
         end
      endcase
   end

   // State registers plus outputs registered from the next state, so every output is a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= C_RST_STATE;
         r_cnt      <= C_INIT_LOAD;
         r_level    <= 1'b0;
         r_shadow   <= 1'b0;
         r_cmd_cnt  <= 8'd0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_in_ready <= 1'b0;
         r_busy     <= C_RST_BUSY;
      end else begin
         r_state    <= w_nstate;
         r_cnt      <= w_ncnt;
         r_level    <= w_nlevel;
         r_shadow   <= w_nshadow;
         r_cmd_cnt  <= w_ncmd_cnt;
         r_s        <= (w_nstate == S_PULSE) & w_nlevel;
         r_r        <= ((w_nstate == S_PULSE) & ~w_nlevel) | (w_nstate == S_INIT);
         r_in_ready <= (w_nstate == S_IDLE);
         r_busy     <= (w_nstate != S_IDLE);
      end
   end

   assign s        = r_s;
   assign r        = r_r;
   assign in_ready = r_in_ready;
   assign busy     = r_busy;
   assign shadow_q = r_shadow;
   assign cmd_cnt  = r_cmd_cnt;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen. Three instances are used:
//   a: defaults (P=1, G=1, INIT_CLEAR=1) - cycle vector table and counter wrap
//   b: P=3, G=0 - alternating back-to-back requests with in_valid held
//   c: P=4, G=2 - INIT timing, asynchronous abort mid-pulse, request latency
module tb_sr_cmd_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic rst_a, v_a, d_a, rdy_a, s_a, r_a, sh_a, busy_a;
   logic [7:0] cnt_a;
   logic rst_b, v_b, d_b, rdy_b, s_b, r_b, sh_b, busy_b;
   logic [7:0] cnt_b;
   logic rst_c, v_c, d_c, rdy_c, s_c, r_c, sh_c, busy_c;
   logic [7:0] cnt_c;

   sr_cmd_gen dut_a (
      .clk(clk), .rst(rst_a), .in_valid(v_a), .in_data(d_a), .in_ready(rdy_a),
      .s(s_a), .r(r_a), .shadow_q(sh_a), .busy(busy_a), .cmd_cnt(cnt_a)
   );

   sr_cmd_gen #(.PULSE_CYCLES(3), .GAP_CYCLES(0), .INIT_CLEAR(1'b1)) dut_b (
      .clk(clk), .rst(rst_b), .in_valid(v_b), .in_data(d_b), .in_ready(rdy_b),
      .s(s_b), .r(r_b), .shadow_q(sh_b), .busy(busy_b), .cmd_cnt(cnt_b)
   );

   sr_cmd_gen #(.PULSE_CYCLES(4), .GAP_CYCLES(2), .INIT_CLEAR(1'b1)) dut_c (
      .clk(clk), .rst(rst_c), .in_valid(v_c), .in_data(d_c), .in_ready(rdy_c),
      .s(s_c), .r(r_c), .shadow_q(sh_c), .busy(busy_c), .cmd_cnt(cnt_c)
   );

   typedef struct packed {
      logic       rst;
      logic       v;
      logic       d;
      logic       rdy;
      logic       s;
      logic       r;
      logic       sh;
      logic       busy;
      logic [7:0] cnt;
   } vec_t;

   localparam int NV = 17;
   vec_t vec [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // s and r must never be high together on any instance.
   always @(negedge clk) begin
      tests++;
      if ((s_a & r_a) | (s_b & r_b) | (s_c & r_c)) begin
         fails++;
         $display("FAIL sr_exclusive: a=%b%b b=%b%b c=%b%b at %0t", s_a, r_a, s_b, r_b, s_c, r_c, $time);
      end
   end

   initial begin
      logic lvl;
      int   n;
      int   shigh;

      rst_a = 1'b1; v_a = 1'b0; d_a = 1'b0;
      rst_b = 1'b1; v_b = 1'b0; d_b = 1'b0;
      rst_c = 1'b1; v_c = 1'b0; d_c = 1'b0;

      //            rst   v     d     rdy   s     r     sh    busy  cnt
      vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
      vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
      vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
      vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
      vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
      vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
      vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
      vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
      vec[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2};
      vec[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
      vec[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
      vec[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
      vec[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
      vec[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3};
      vec[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
      vec[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};

      // ---- instance a: cycle-by-cycle vector table ----
      for (int i = 0; i < NV; i++) begin
         rst_a = vec[i].rst;
         v_a   = vec[i].v;
         d_a   = vec[i].d;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d {rdy,s,r,sh,busy,cnt}", i),
               {19'd0, rdy_a, s_a, r_a, sh_a, busy_a, cnt_a},
               {19'd0, vec[i].rdy, vec[i].s, vec[i].r, vec[i].sh, vec[i].busy, vec[i].cnt});
      end

      // ---- instance a: 256 alternating requests, cmd_cnt wraps ----
      for (int i = 0; i < 256; i++) begin
         n = 0;
         while (!rdy_a && n < 20) begin
            @(posedge clk); #1; n++;
         end
         check("a_wrap_rdy", {31'd0, rdy_a}, 32'd1);
         if (i == 255) begin
            check("a_cnt_255", {24'd0, cnt_a}, 32'd255);
            check("a_sh_255", {31'd0, sh_a}, 32'd1);
         end
         v_a = 1'b1;
         d_a = ((i % 2) == 0) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         v_a = 1'b0;
      end
      n = 0;
      while (!rdy_a && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("a_wrap_final_rdy", {31'd0, rdy_a}, 32'd1);
      check("a_cnt_wrap", {24'd0, cnt_a}, 32'd0);
      check("a_sh_final", {31'd0, sh_a}, 32'd0);

      // ---- instance b: P=3 G=0, alternating 1,0,1 with in_valid held ----
      @(posedge clk); #1;
      rst_b = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         check($sformatf("b_init_r_e%0d", e), {31'd0, r_b}, {31'd0, (e <= 3)});
         check($sformatf("b_init_rdy_e%0d", e), {31'd0, rdy_b}, {31'd0, (e == 4)});
      end
      for (int k = 0; k < 3; k++) begin
         lvl = (k == 1) ? 1'b0 : 1'b1;
         n = 0;
         while (!rdy_b && n < 20) begin
            @(posedge clk); #1; n++;
         end
         check("b_rdy", {31'd0, rdy_b}, 32'd1);
         v_b = 1'b1;
         d_b = lvl;
         @(posedge clk); #1;
         n = 0;
         while ((lvl ? s_b : r_b) && n < 20) begin
            n++;
            @(posedge clk); #1;
         end
         check($sformatf("b_pulse_len_k%0d", k), n, 32'd3);
      end
      check("b_cnt", {24'd0, cnt_b}, 32'd3);
      check("b_sh", {31'd0, sh_b}, 32'd1);
      @(posedge clk); #1;
      check("b_held_same_level_no_pulse", {30'd0, s_b, r_b}, 32'd0);
      check("b_cnt_after_hold", {24'd0, cnt_b}, 32'd3);
      v_b = 1'b0;

      // ---- instance c: P=4 G=2, INIT timing ----
      rst_c = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         @(posedge clk); #1;
         check($sformatf("c_init_r_e%0d", e), {31'd0, r_c}, {31'd0, (e <= 4)});
         check($sformatf("c_init_rdy_e%0d", e), {31'd0, rdy_c}, {31'd0, (e == 7)});
      end

      // abort on the second cycle of a set pulse
      v_c = 1'b1; d_c = 1'b1;
      @(posedge clk); #1;
      v_c = 1'b0;
      check("c_pulse_cyc1", {23'd0, s_c, cnt_c}, {23'd0, 1'b1, 8'd1});
      @(posedge clk); #1;
      check("c_pulse_cyc2", {31'd0, s_c}, 32'd1);
      #1 rst_c = 1'b1;
      #1;
      check("c_abort {s,r,rdy,sh,cnt}", {20'd0, s_c, r_c, rdy_c, sh_c, cnt_c}, 32'd0);
      check("c_abort_busy", {31'd0, busy_c}, 32'd1);
      @(posedge clk); #1;
      rst_c = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         @(posedge clk); #1;
         check($sformatf("c_reinit_r_e%0d", e), {31'd0, r_c}, {31'd0, (e <= 4)});
         check($sformatf("c_reinit_rdy_e%0d", e), {31'd0, rdy_c}, {31'd0, (e == 7)});
      end

      // full pulse: width and request-to-ready latency P+G+1 = 7 edges
      v_c = 1'b1; d_c = 1'b1;
      @(posedge clk); #1;
      v_c = 1'b0;
      n = 1;
      shigh = int'(s_c);
      while (!rdy_c && n < 40) begin
         @(posedge clk); #1;
         n++;
         shigh += int'(s_c);
      end
      check("c_latency", n, 32'd7);
      check("c_s_width", shigh, 32'd4);
      check("c_sh", {31'd0, sh_c}, 32'd1);
      check("c_cnt", {24'd0, cnt_c}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
